// File: rtl/pwl_act_unit.sv
// pwl_act_unit: 3-stage piecewise-linear sigmoid/tanh with valid/ready stream.
// Define PWL_TANH_EN to build the tanh path (in_mode=1); otherwise sigmoid only.
module pwl_act_unit #(
  parameter int DW   = 32,
  parameter int FRAC = 12,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_x,
  input  logic            in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_y,
  output logic [TAGW-1:0] out_tag
);

  localparam logic [DW-1:0] ONE  = DW'(1) << FRAC;
  localparam logic [DW-1:0] T1   = ONE;
  localparam logic [DW-1:0] T2   = DW'(19) << (FRAC - 3);
  localparam logic [DW-1:0] T3   = DW'(5) << FRAC;
  localparam logic [DW-1:0] B0   = DW'(1) << (FRAC - 1);
  localparam logic [DW-1:0] B1   = DW'(5) << (FRAC - 3);
  localparam logic [DW-1:0] B2   = DW'(27) << (FRAC - 5);
  localparam logic [DW-1:0] AMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic            sign;
    logic [DW-1:0]   a;
    logic            mode;
    logic [TAGW-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic            sign;
    logic [DW-1:0]   p;
    logic [DW-1:0]   bias;
    logic            mode;
    logic [TAGW-1:0] tag;
  } s2_t;

  logic    en;
  logic    v1, v2;
  s1_t     s1_d, s1_q;
  s2_t     s2_d, s2_q;
  logic [DW-1:0] abs_x;
  logic [DW-1:0] s_sum;
  logic [DW-1:0] y_ref;
  logic [DW-1:0] y_out;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    abs_x = in_x;
    if (in_x[DW-1])
      abs_x = (in_x == NMIN) ? AMAX : -in_x;
    s1_d      = '0;
    s1_d.sign = in_x[DW-1];
    s1_d.tag  = in_tag;
`ifdef PWL_TANH_EN
    s1_d.mode = in_mode;
    if (!in_mode)
      s1_d.a = abs_x;
    else if (abs_x[DW-2])
      s1_d.a = AMAX;
    else
      s1_d.a = abs_x << 1;
`else
    s1_d.mode = 1'b0;
    s1_d.a    = abs_x;
`endif
  end

`ifndef PWL_TANH_EN
  logic unused_mode;
  assign unused_mode = in_mode;
`endif

  // Breakpoints belong to the upper segment.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.mode = s1_q.mode;
    s2_d.tag  = s1_q.tag;
    s2_d.bias = ONE;
    unique case (1'b1)
      (s1_q.a < T1): begin
        s2_d.p    = s1_q.a >> 2;
        s2_d.bias = B0;
      end
      (s1_q.a >= T1 && s1_q.a < T2): begin
        s2_d.p    = s1_q.a >> 3;
        s2_d.bias = B1;
      end
      (s1_q.a >= T2 && s1_q.a < T3): begin
        s2_d.p    = s1_q.a >> 5;
        s2_d.bias = B2;
      end
      default: begin
        s2_d.p    = '0;
        s2_d.bias = ONE;
      end
    endcase
  end

  always_comb begin
    s_sum = s2_q.p + s2_q.bias;
    y_ref = s2_q.sign ? (ONE - s_sum) : s_sum;
    y_out = y_ref;
`ifdef PWL_TANH_EN
    if (s2_q.mode)
      y_out = (y_ref << 1) - ONE;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_y <= '0;
      out_tag <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      out_y <= y_out;
      out_tag <= s2_q.tag;
    end
  end

  // Data-only stage registers; only the valids need reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_pwl_act_unit.sv
// tb_pwl_act_unit: scoreboard bench for pwl_act_unit.
// Tanh expectations follow PWL_TANH_EN.
module tb_pwl_act_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        in_mode;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [7:0]  out_tag;

  typedef struct {
    logic [31:0] y;
    logic [7:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] cur_exp;
  bit          cur_lat;
  logic [7:0]  tag_ctr = 8'd1;
  bit          held = 0;
  logic [31:0] held_y;
  logic [7:0]  held_tag;

  pwl_act_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, $signed(obs),
             $signed(exp));
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] xv, input bit m);
    longint a, s, y;
    bit     neg;
`ifndef PWL_TANH_EN
    m = 0;
`endif
    neg = xv[31];
    a = neg ? -longint'($signed(xv)) : longint'($signed(xv));
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (m) begin
      a = 2 * a;
      if (a > 64'sd2147483647) a = 64'sd2147483647;
    end
    if (a < 4096) s = (a >> 2) + 2048;
    else if (a < 9728) s = (a >> 3) + 2560;
    else if (a < 20480) s = (a >> 5) + 3456;
    else s = 4096;
    y = neg ? 4096 - s : s;
    if (m) y = 2 * y - 4096;
    return y[31:0];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready)
        q.push_back('{y: cur_exp, tag: in_tag, cyc: cyc, lat: cur_lat});
      if (out_valid) begin
        if (held) begin
          chk("stall_y_stable", out_y, held_y);
          chk("stall_tag_stable", {24'd0, out_tag}, {24'd0, held_tag});
        end
        if (out_ready) begin
          held = 0;
          if (q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_y", out_y, e.y);
            chk("out_tag", {24'd0, out_tag}, {24'd0, e.tag});
            if (e.lat) chk("latency", cyc - e.cyc, 32'd3);
          end
        end else begin
          chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
          held = 1;
          held_y = out_y;
          held_tag = out_tag;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic send(input logic [31:0] xv, input bit m,
                      input logic [31:0] e, input bit lat);
    bit ok = 0;
    in_valid = 1'b1;
    in_x = xv;
    in_mode = m;
    in_tag = tag_ctr;
    tag_ctr++;
    cur_exp = e;
    cur_lat = lat;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1x[5] = '{32'd0, 32'd4096, -32'sd4096, 32'd9728, 32'd20480};
    logic [31:0] t1y[5] = '{32'd2048, 32'd3072, 32'd1024, 32'd3760, 32'd4096};
    logic [31:0] t2x[3] = '{32'd4095, 32'd4096, 32'h8000_0000};
    logic [31:0] t2y[3] = '{32'd3071, 32'd3072, 32'd0};
    logic [31:0] t3x[4] = '{32'd0, 32'd2048, -32'sd2048, 32'h7fff_ffff};
`ifdef PWL_TANH_EN
    logic [31:0] t3y[4] = '{32'd0, 32'd2048, -32'sd2048, 32'd4096};
    logic [31:0] tany = 32'd2048;
`else
    logic [31:0] t3y[4] = '{32'd2048, 32'd2560, 32'd1536, 32'd4096};
    logic [31:0] tany = 32'd2560;
`endif
    reset = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_mode = 1'b0;
    in_tag = '0;
    out_ready = 1'b1;
    cur_exp = '0;
    cur_lat = 0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_tag", {24'd0, out_tag}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 5; i++) send(t1x[i], 1'b0, t1y[i], 1'b1);
    drain();

    for (int i = 0; i < 3; i++) send(t2x[i], 1'b0, t2y[i], 1'b1);
    drain();

    for (int i = 0; i < 4; i++) send(t3x[i], 1'b1, t3y[i], 1'b1);
    drain();

    for (int i = 0; i < 6; i++)
      send(32'd2048, i[0], i[0] ? tany : 32'd2560, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int r;
          logic [31:0] xv;
          bit m;
          r = $urandom();
          xv = 32'(r >>> $urandom_range(14, 28));
          m = bit'($urandom_range(0, 1));
          send(xv, m, model(xv, m), 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++)
      send(32'd4096 * i, 1'b0, model(32'd4096 * i, 1'b0), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_y", out_y, 32'd0);
    chk("mid_rst_out_tag", {24'd0, out_tag}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(-32'sd4096, 1'b0, 32'd1024, 1'b1);
    drain();
    repeat (6) @(posedge clk);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
